any1_vec_sequencer: RTL

ANY1_VEC_SEQUENCER -- requirements
Module: any1_vec_sequencer

---
 rtl/any1_vec_sequencer_pkg.sv | 22 ++
 rtl/any1_vec_sequencer_if.sv | 28 ++
 rtl/any1_vec_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/any1_vec_sequencer_pkg.sv
// Shared types and constants for the vector element sequencer.
package any1_pkg;

  localparam int VLMAX_DEF = 64;
  localparam int VL_W      = 7;
  localparam int VEN_W     = 6;
  localparam int VM_W      = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Clamp the requested vector length to the hardware maximum.
  function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl,
                                               input int unsigned       vlmax);
    logic [VL_W-1:0] lim;
    lim = VL_W'(vlmax);
    return (vl > lim) ? lim : vl;
  endfunction

endpackage

// File: rtl/any1_vec_sequencer_if.sv
// Decoder-to-issue handshake bundle seen by the vector element sequencer.
interface any1_vec_sequencer_if;
  import any1_pkg::*;

  logic             dec_v;
  logic             is_vec;
  logic [VL_W-1:0]  vl;
  logic             vmask_en;
  logic [VM_W-1:0]  vm;
  logic             iss_rdy;
  logic             flush;
  logic [VEN_W-1:0] ven;
  logic             iss_v;
  logic             iss_last;
  logic             dec_ack;
  logic             fetch_stall;

  modport master (
    output dec_v, is_vec, vl, vmask_en, vm, iss_rdy, flush,
    input  ven, iss_v, iss_last, dec_ack, fetch_stall
  );

  modport slave (
    input  dec_v, is_vec, vl, vmask_en, vm, iss_rdy, flush,
    output ven, iss_v, iss_last, dec_ack, fetch_stall
  );

endinterface

// File: rtl/any1_vec_sequencer.sv
// Steps a decoded vector instruction through its elements one per issue slot,
// skipping masked-off elements; scalar instructions pass straight through.
module any1_vec_sequencer
  import any1_pkg::*;
#(
  parameter int VLMAX = VLMAX_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  any1_vec_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  logic [VEN_W-1:0] ven_q, ven_d;
  logic [VL_W-1:0]  evl_q, evl_d;
  logic             msk_en_q, msk_en_d;
  logic [VM_W-1:0]  vm_q, vm_d;

  logic [VL_W-1:0]  evl_in;
  logic             elem_en;
  logic             elem_last;
  logic             advance;

  assign evl_in    = clamp_vl(bus.vl, VLMAX);
  assign elem_en   = !msk_en_q || vm_q[ven_q];
  assign elem_last = ({1'b0, ven_q} == VL_W'(evl_q - VL_W'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ven_q    <= '0;
      evl_q    <= '0;
      msk_en_q <= 1'b0;
      vm_q     <= '0;
    end else begin
      state_q  <= state_d;
      ven_q    <= ven_d;
      evl_q    <= evl_d;
      msk_en_q <= msk_en_d;
      vm_q     <= vm_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ven_d           = ven_q;
    evl_d           = evl_q;
    msk_en_d        = msk_en_q;
    vm_d            = vm_q;
    advance         = 1'b0;
    bus.ven         = ven_q;
    bus.iss_v       = 1'b0;
    bus.iss_last    = 1'b0;
    bus.dec_ack     = 1'b0;
    bus.fetch_stall = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.dec_v) begin
          if (!bus.is_vec) begin
            bus.iss_v       = 1'b1;
            bus.iss_last    = 1'b1;
            bus.dec_ack     = bus.iss_rdy;
            bus.fetch_stall = !bus.iss_rdy;
          end else if (evl_in == '0) begin
            bus.dec_ack = 1'b1;
          end else begin
            // Capture the length and mask so later CSR/mask writes cannot disturb this instruction.
            state_d         = ST_RUN;
            ven_d           = '0;
            evl_d           = evl_in;
            msk_en_d        = bus.vmask_en;
            vm_d            = bus.vm;
            bus.fetch_stall = 1'b1;
          end
        end
      end

      ST_RUN: begin
        bus.iss_last    = elem_last;
        bus.fetch_stall = 1'b1;
        if (elem_en) begin
          bus.iss_v = 1'b1;
          advance   = bus.iss_rdy;
        end else begin
          advance   = 1'b1;
        end
        if (advance) begin
          if (elem_last) begin
            bus.dec_ack     = 1'b1;
            bus.fetch_stall = 1'b0;
            state_d         = ST_IDLE;
            ven_d           = '0;
          end else begin
            ven_d = ven_q + VEN_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A flush abandons whatever is in flight, including a same-cycle completion.
    if (bus.flush) begin
      state_d     = ST_IDLE;
      ven_d       = '0;
      bus.dec_ack = 1'b0;
      bus.iss_v   = 1'b0;
    end
  end

endmodule
